pong_control: RTL

// - Top-level FSM for VGA Pong. Sequences the pong datapath strobes: clear, set-ups, draws, moves, reset_delta, menu.
// - Generates VGA plot enable and an internal frame tick.
// - Handles menu, run and game-over. Sits between keyboard/start logic and the datapath; the datapath drives x/y/colour.

---
 rtl/pong_control_if.sv | 36 +++
 rtl/pong_control.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pong_control_if.sv
// Control bus between pong_control and the keyboard/start logic and Pong datapath.
// The master side is the sequencer. The slave side drives the inputs and consumes the strobes.
interface pong_control_if;
    logic       start;
    logic       gameover;
    logic       menu;
    logic       reset_delta;
    logic       set_up_clear_screen;
    logic       set_up_left_pad;
    logic       set_up_right_pad;
    logic       set_up_ball;
    logic       clear_screen;
    logic       draw_left_pad;
    logic       draw_right_pad;
    logic       draw_ball;
    logic       move_pads;
    logic       move_ball;
    logic       plot;
    logic [3:0] state;

    modport master (
        input  start, gameover,
        output menu, reset_delta,
        output set_up_clear_screen, set_up_left_pad, set_up_right_pad, set_up_ball,
        output clear_screen, draw_left_pad, draw_right_pad, draw_ball,
        output move_pads, move_ball, plot, state
    );

    modport slave (
        output start, gameover,
        input  menu, reset_delta,
        input  set_up_clear_screen, set_up_left_pad, set_up_right_pad, set_up_ball,
        input  clear_screen, draw_left_pad, draw_right_pad, draw_ball,
        input  move_pads, move_ball, plot, state
    );
endinterface

// File: rtl/pong_control.sv
// Top-level Moore FSM for VGA Pong. It sequences the clear, draw and move strobes
// for the datapath, generates the VGA plot enable, and holds frame ticks until they are consumed.
module pong_control #(
    parameter int CLEAR_PIXELS = 19200,
    parameter int PAD_PIXELS   = 32,
    parameter int BALL_PIXELS  = 16,
    parameter int FRAME_DIV    = 833333
) (
    input  logic           clk,
    input  logic           resetn,
    pong_control_if.master bus
);

    typedef enum logic [3:0] {
        S_MENU     = 4'd0,
        S_MENU_REL = 4'd1,
        S_CLR_SU   = 4'd2,
        S_CLR      = 4'd3,
        S_LP_SU    = 4'd4,
        S_LP       = 4'd5,
        S_RP_SU    = 4'd6,
        S_RP       = 4'd7,
        S_BL_SU    = 4'd8,
        S_BL       = 4'd9,
        S_WAIT     = 4'd10,
        S_MOVE     = 4'd11,
        S_SETTLE   = 4'd12,
        S_OVER     = 4'd13,
        S_OVER_REL = 4'd14
    } state_t;

    localparam int FRAME_W = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;

    localparam logic [14:0]        CLR_LAST   = 15'(CLEAR_PIXELS - 1);
    localparam logic [14:0]        PAD_LAST   = 15'(PAD_PIXELS - 1);
    localparam logic [14:0]        BALL_LAST  = 15'(BALL_PIXELS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_DIV - 1);

    // The set-up and draw phases appear in the same order: clear, left pad, right pad, ball.
    localparam state_t SU_STATES   [4] = '{S_CLR_SU, S_LP_SU, S_RP_SU, S_BL_SU};
    localparam state_t DRAW_STATES [4] = '{S_CLR,    S_LP,    S_RP,    S_BL};

    state_t             state_reg, state_next;
    logic [14:0]        pix_cnt_reg, pix_cnt_next;
    logic [FRAME_W-1:0] frame_cnt_reg;
    logic               frame_pending_reg;
    logic               plot_reg;
    logic               frame_tc;
    logic               consume;
    logic [3:0]         su_hit;
    logic [3:0]         draw_hit;
    logic               drawing;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_phase
            assign su_hit[gi]   = (state_reg == SU_STATES[gi]);
            assign draw_hit[gi] = (state_reg == DRAW_STATES[gi]);
        end
    endgenerate

    assign drawing  = |draw_hit;
    assign frame_tc = (frame_cnt_reg == FRAME_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg         <= S_MENU;
            pix_cnt_reg       <= '0;
            frame_cnt_reg     <= '0;
            frame_pending_reg <= 1'b0;
            plot_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            pix_cnt_reg       <= pix_cnt_next;
            frame_cnt_reg     <= frame_tc ? '0 : frame_cnt_reg + FRAME_W'(1);
            // A new tick wins over a same-cycle consume, so no tick is ever dropped.
            frame_pending_reg <= frame_tc | (frame_pending_reg & ~consume);
            // Delayed one cycle to line up with the datapath's registered x/y.
            plot_reg          <= drawing;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pix_cnt_next = pix_cnt_reg;
        consume      = 1'b0;
        case (state_reg)
            S_MENU:     if (bus.start)  state_next = S_MENU_REL;
            S_MENU_REL: if (!bus.start) state_next = S_CLR_SU;
            S_CLR_SU: begin
                pix_cnt_next = '0;
                state_next   = S_CLR;
            end
            S_CLR: begin
                if (pix_cnt_reg == CLR_LAST) state_next   = S_LP_SU;
                else                         pix_cnt_next = pix_cnt_reg + 15'd1;
            end
            S_LP_SU: begin
                pix_cnt_next = '0;
                state_next   = S_LP;
            end
            S_LP: begin
                if (pix_cnt_reg == PAD_LAST) state_next   = S_RP_SU;
                else                         pix_cnt_next = pix_cnt_reg + 15'd1;
            end
            S_RP_SU: begin
                pix_cnt_next = '0;
                state_next   = S_RP;
            end
            S_RP: begin
                if (pix_cnt_reg == PAD_LAST) state_next   = S_BL_SU;
                else                         pix_cnt_next = pix_cnt_reg + 15'd1;
            end
            S_BL_SU: begin
                pix_cnt_next = '0;
                state_next   = S_BL;
            end
            S_BL: begin
                if (pix_cnt_reg == BALL_LAST) state_next   = S_WAIT;
                else                          pix_cnt_next = pix_cnt_reg + 15'd1;
            end
            S_WAIT: begin
                if (frame_pending_reg) begin
                    consume    = 1'b1;
                    state_next = S_MOVE;
                end
            end
            S_MOVE:     state_next = S_SETTLE;
            // gameover is sampled one cycle after MOVE so it reflects the updated scores.
            S_SETTLE:   state_next = bus.gameover ? S_OVER : S_CLR_SU;
            S_OVER:     if (bus.start)  state_next = S_OVER_REL;
            S_OVER_REL: if (!bus.start) state_next = S_MENU;
            default:    state_next = S_MENU;
        endcase
    end

    assign bus.menu                = (state_reg == S_MENU) || (state_reg == S_MENU_REL);
    assign bus.reset_delta         = |su_hit;
    assign bus.set_up_clear_screen = su_hit[0];
    assign bus.set_up_left_pad     = su_hit[1];
    assign bus.set_up_right_pad    = su_hit[2];
    assign bus.set_up_ball         = su_hit[3];
    assign bus.clear_screen        = draw_hit[0];
    assign bus.draw_left_pad       = draw_hit[1];
    assign bus.draw_right_pad      = draw_hit[2];
    assign bus.draw_ball           = draw_hit[3];
    assign bus.move_pads           = (state_reg == S_MOVE);
    assign bus.move_ball           = (state_reg == S_MOVE);
    assign bus.plot                = plot_reg;
    assign bus.state               = state_reg;

endmodule
